// File: rtl/phy_pkg.sv
// phy_pkg: link constants and tx slot FSM state shared by the serializer and deserializer.
package phy_pkg;
  localparam logic [7:0] COMMA_BYTE = 8'hBC;
  localparam int DEF_SYNC_COUNT = 4;
  typedef enum logic {SYNC, DATA} tx_state_t;
endpackage

// File: rtl/ps_hold_reg.sv
// ps_hold_reg: one-entry valid/ready holding register feeding the serializer slot loader.
module ps_hold_reg (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  input  logic       pass,
  input  logic       pop,
  output logic       ready_out,
  output logic [7:0] hold_data,
  output logic       hold_valid
);
  logic push;
  // pass lets a new byte in during the same cycle the held one is consumed
  assign ready_out = !hold_valid || pass;
  assign push = valid_in && ready_out;
  always_ff @(posedge clk_32f or negedge reset)
    if (!reset) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else begin
      hold_valid <= push || (hold_valid && !pop);
      if (push) hold_data <= data_in;
    end
endmodule

// File: rtl/paralelo_serial_tx.sv
// paralelo_serial_tx: MSB-first byte serializer framed by COMMA sync burst and fill bytes.
// Define PS_TX_COUNT_EN to add the tx_count data-byte counter output.
module paralelo_serial_tx
  import phy_pkg::*;
#(
  parameter int         SYNC_COUNT = DEF_SYNC_COUNT,
  parameter logic [7:0] COMMA      = COMMA_BYTE
) (
  input  logic        clk_32f,
  input  logic        reset,
  input  logic [7:0]  data_in,
  input  logic        valid_in,
  output logic        ready_out,
  output logic        serial_out,
  output logic        active_out,
  output logic        idle_out,
`ifdef PS_TX_COUNT_EN
  output logic [15:0] tx_count,
`endif
  output logic        byte_start
);
  tx_state_t  state, state_d;
  logic [7:0] shreg, shreg_d, hold_data;
  logic [3:0] sync_cnt, sync_d;
  logic [2:0] bit_cnt;
  logic       slot_idle, idle_d, hold_valid, pop, pass, last;

  assign last       = bit_cnt == 3'd7;
  assign pass       = state == DATA && last;
  assign serial_out = shreg[7];
  assign active_out = state == DATA;
  assign idle_out   = slot_idle;
  assign byte_start = bit_cnt == 3'd0;

  ps_hold_reg u_hold (
    .clk_32f   (clk_32f),
    .reset     (reset),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .pass      (pass),
    .pop       (pop),
    .ready_out (ready_out),
    .hold_data (hold_data),
    .hold_valid(hold_valid)
  );

  // The comma loaded at reset is the first of the burst, hence sync_cnt starts at 1
  always_comb begin
    state_d = state;
    sync_d  = sync_cnt;
    shreg_d = {shreg[6:0], 1'b0};
    idle_d  = slot_idle;
    pop     = 1'b0;
    if (last) begin
      if (state == SYNC && sync_cnt < 4'(SYNC_COUNT)) begin
        shreg_d = COMMA;
        sync_d  = sync_cnt + 4'd1;
        idle_d  = 1'b1;
      end else begin
        state_d = DATA;
        pop     = hold_valid;
        shreg_d = hold_valid ? hold_data : COMMA;
        idle_d  = !hold_valid;
      end
    end
  end

  always_ff @(posedge clk_32f or negedge reset)
    if (!reset) begin
      state     <= SYNC;
      shreg     <= COMMA;
      sync_cnt  <= 4'd1;
      bit_cnt   <= 3'd0;
      slot_idle <= 1'b1;
    end else begin
      state     <= state_d;
      shreg     <= shreg_d;
      sync_cnt  <= sync_d;
      bit_cnt   <= bit_cnt + 3'd1;
      slot_idle <= idle_d;
    end

`ifdef PS_TX_COUNT_EN
  always_ff @(posedge clk_32f or negedge reset)
    if (!reset) tx_count <= '0;
    else if (pop) tx_count <= tx_count + 16'd1;
`endif
endmodule
